// File: rtl/stage_sequencer.sv
// Steps the datapath through STAGE_COUNT stages with one-hot write enables, one stage per cycle.
// Enables are combinational from registered stage plus run/stall; stalls and run=0 hold the slot.
module stage_sequencer #(
  parameter int STAGE_COUNT       = 5,
  parameter int RAM_STAGE         = 3,
  parameter int REG_STAGE         = 4,
  parameter int RESET_HOLD_CYCLES = 2,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           run,
  input  logic [STAGE_COUNT-1:0]         stall_req,
  input  logic                           halt,
  input  logic                           resume,
  output logic [STAGE_COUNT-1:0]         stage_wren,
  output logic                           ram_wren,
  output logic                           reg_wren,
  output logic                           pipeline_register_reset_n,
  output logic [$clog2(STAGE_COUNT)-1:0] active_stage,
  output logic                           halted,
  output logic                           retire,
  output logic [COUNTER_WIDTH-1:0]       cycle_count,
  output logic [COUNTER_WIDTH-1:0]       instret_count,
  output logic [COUNTER_WIDTH-1:0]       stall_count
);

  localparam int AW = $clog2(STAGE_COUNT);
  localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
  localparam logic [AW-1:0] LAST_STAGE = AW'(STAGE_COUNT - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALTED} state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            halt_pending;
  logic            stalled;
  logic            in_run;

  // Only the active stage's stall bit matters; the others are ignored.
  assign stalled = stall_req[active_stage];
  assign in_run  = (state == S_RUN);

  always_comb begin
    stage_wren = '0;
    if (in_run && run && !stalled)
      stage_wren[active_stage] = 1'b1;
  end

  assign ram_wren                  = stage_wren[RAM_STAGE];
  assign reg_wren                  = stage_wren[REG_STAGE];
  assign retire                    = stage_wren[STAGE_COUNT-1];
  assign pipeline_register_reset_n = (state != S_RESET);
  assign halted                    = (state == S_HALTED);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_RESET;
      active_stage  <= '0;
      hold_cnt      <= '0;
      halt_pending  <= 1'b0;
      cycle_count   <= '0;
      instret_count <= '0;
      stall_count   <= '0;
    end else begin
      case (state)
        S_RESET: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HOLD_LAST) begin
            state        <= S_RUN;
            active_stage <= '0;
          end
        end
        S_RUN: begin
          if (run)
            cycle_count <= cycle_count + COUNTER_WIDTH'(1);
          if (run && stalled)
            stall_count <= stall_count + COUNTER_WIDTH'(1);
          if (retire)
            instret_count <= instret_count + COUNTER_WIDTH'(1);
          if (|stage_wren)
            active_stage <= (active_stage == LAST_STAGE) ? '0 : active_stage + AW'(1);
          // The retiring instruction completes; the halt takes effect at the boundary.
          if (retire && (halt_pending || halt)) begin
            state        <= S_HALTED;
            active_stage <= '0;
            halt_pending <= 1'b0;
          end else if (halt) begin
            halt_pending <= 1'b1;
          end
        end
        S_HALTED: begin
          if (resume)
            state <= S_RUN;
        end
        default: state <= S_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: directed scenarios plus random stimulus against a behavioural model.
module tb_stage_sequencer;
  localparam int N    = 5;
  localparam int RAMS = 3;
  localparam int REGS = 4;
  localparam int HOLD = 2;
  localparam int CW   = 32;
  localparam longint MASK = (longint'(1) << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, run = 1'b1, halt = 1'b0, resume = 1'b0;
  logic [N-1:0]  stall_req = '0;
  logic [N-1:0]  stage_wren;
  logic          ram_wren, reg_wren, pipeline_register_reset_n, halted, retire;
  logic [2:0]    active_stage;
  logic [CW-1:0] cycle_count, instret_count, stall_count;

  logic          reset3 = 1'b1;
  logic [2:0]    stage_wren3;
  logic          ram_wren3, reg_wren3, prr_n3, halted3, retire3;
  logic [1:0]    active_stage3;
  logic [3:0]    cycle_count3, instret_count3, stall_count3;

  stage_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .stall_req(stall_req), .halt(halt), .resume(resume),
    .stage_wren(stage_wren), .ram_wren(ram_wren), .reg_wren(reg_wren),
    .pipeline_register_reset_n(pipeline_register_reset_n), .active_stage(active_stage),
    .halted(halted), .retire(retire), .cycle_count(cycle_count),
    .instret_count(instret_count), .stall_count(stall_count)
  );

  stage_sequencer #(.STAGE_COUNT(3), .RAM_STAGE(1), .REG_STAGE(2),
                    .RESET_HOLD_CYCLES(2), .COUNTER_WIDTH(4)) dut3 (
    .clk(clk), .reset(reset3), .run(1'b1), .stall_req(3'b000), .halt(1'b0), .resume(1'b0),
    .stage_wren(stage_wren3), .ram_wren(ram_wren3), .reg_wren(reg_wren3),
    .pipeline_register_reset_n(prr_n3), .active_stage(active_stage3),
    .halted(halted3), .retire(retire3), .cycle_count(cycle_count3),
    .instret_count(instret_count3), .stall_count(stall_count3)
  );

  int errs = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 = held in reset, 1 = sequencing, 2 = halted.
  int     m_mode = 0, m_hold = 0, m_stage = 0;
  bit     m_pend = 0;
  longint m_cyc = 0, m_ins = 0, m_stl = 0;
  logic [N-1:0] obs_wren;
  logic         obs_prn;

  function automatic logic [N-1:0] exp_wren();
    logic [N-1:0] e = '0;
    if (m_mode == 1 && run && !stall_req[m_stage]) e[m_stage] = 1'b1;
    return e;
  endfunction

  task automatic model_step(input logic [N-1:0] e);
    bit ret;
    ret = e[N-1];
    if (reset) begin
      m_mode = 0; m_hold = 0; m_stage = 0; m_pend = 0;
      m_cyc = 0; m_ins = 0; m_stl = 0;
    end else if (m_mode == 0) begin
      if (m_hold == HOLD - 1) begin m_mode = 1; m_stage = 0; end
      m_hold++;
    end else if (m_mode == 1) begin
      if (run) m_cyc = (m_cyc + 1) & MASK;
      if (run && stall_req[m_stage]) m_stl = (m_stl + 1) & MASK;
      if (ret) m_ins = (m_ins + 1) & MASK;
      if (e != 0) m_stage = (m_stage + 1) % N;
      if (ret && (m_pend || halt)) begin m_mode = 2; m_stage = 0; m_pend = 0; end
      else if (halt) m_pend = 1;
    end else begin
      if (resume) m_mode = 1;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] e;
    @(negedge clk);
    e = exp_wren();
    obs_wren = stage_wren;
    obs_prn  = pipeline_register_reset_n;
    check("stage_wren", stage_wren, e);
    check("ram_wren", ram_wren, e[RAMS]);
    check("reg_wren", reg_wren, e[REGS]);
    check("retire", retire, e[N-1]);
    check("onehot", $onehot0(stage_wren), 1);
    check("prr_n", pipeline_register_reset_n, m_mode != 0);
    check("halted", halted, m_mode == 2);
    check("active_stage", active_stage, m_stage);
    check("cycle_count", cycle_count, m_cyc);
    check("instret_count", instret_count, m_ins);
    check("stall_count", stall_count, m_stl);
    @(posedge clk);
    model_step(e);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b1; halt = 1'b0; resume = 1'b0; stall_req = '0;
    cycle(); cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset release and one clean instruction
    do_reset();
    for (int c = 1; c <= 7; c++) begin
      cycle();
      if (c <= 2) check("rel_prr_low", obs_prn, 0);
      else        check("rel_wren_seq", obs_wren, 5'b00001 << (c - 3));
    end
    check("rel_instret", instret_count, 1);

    // Stall on stage 3 for four cycles
    do_reset();
    repeat (5) cycle();
    stall_req = 5'b01000;
    repeat (4) begin cycle(); check("stall_wren_zero", obs_wren, 0); end
    stall_req = '0;
    cycle(); check("stall_release", obs_wren, 5'b01000);
    cycle();
    check("stall_cnt", stall_count, 4);
    check("stall_cyc", cycle_count, 9);
    check("stall_ins", instret_count, 1);

    // Pause during stage 2
    do_reset();
    repeat (4) cycle();
    run = 1'b0;
    repeat (3) begin
      cycle();
      check("pause_stage", active_stage, 2);
      check("pause_cyc", cycle_count, 2);
      check("pause_wren", obs_wren, 0);
    end
    run = 1'b1;
    cycle(); check("pause_resume", obs_wren, 5'b00100);
    repeat (2) cycle();

    // Halt pulse during stage 1, then resume
    do_reset();
    repeat (3) cycle();
    halt = 1'b1; cycle(); halt = 1'b0;
    repeat (3) cycle();
    check("halt_retired", instret_count, 1);
    check("halt_flag", halted, 1);
    repeat (10) begin cycle(); check("halt_quiet", obs_wren, 0); end
    resume = 1'b1; cycle(); resume = 1'b0;
    cycle(); check("resume_s0", obs_wren, 5'b00001);

    // Reset asserted in stage 3 with counters nonzero
    repeat (2) cycle();
    check("pre_rst_stage", active_stage, 3);
    reset = 1'b1; cycle(); reset = 1'b0;
    check("rst_cyc", cycle_count, 0);
    check("rst_ins", instret_count, 0);
    check("rst_prr", pipeline_register_reset_n, 0);
    check("rst_stage", active_stage, 0);
    check("rst_wren", stage_wren, 0);
    repeat (2) cycle();
    cycle(); check("rst_restart", obs_wren, 5'b00001);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      reset     = ($urandom_range(199) == 0);
      run       = ($urandom_range(99) < 85);
      halt      = ($urandom_range(99) < 3);
      resume    = ($urandom_range(99) < 10);
      stall_req = '0;
      for (int k = 0; k < N; k++) stall_req[k] = ($urandom_range(99) < 15);
      cycle();
    end

    // Narrow instance: counter wrap with three stages, four-bit counters
    reset3 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 1; k <= 16; k++) begin
      repeat (3) begin @(posedge clk); #1; end
      check("wrap_instret", instret_count3, k % 16);
      check("wrap_cycle", cycle_count3, (3 * k) % 16);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised stage sequencer for the multi-cycle CPU core. It steps the datapath through STAGE_COUNT stages by issuing one-hot pipeline-register write enables, one stage per cycle. Any stage may stretch its slot with a stall request. The block also supports pause (run), halt at an instruction boundary and resume, and keeps cycle, retired-instruction and stall counters. It sits at the core top level, driving the pipeline-register enables and the RAM/register-file write strobes.

## Interface
- STAGE_COUNT, 5: number of sequenced stages (≥2); stage 0 = fetch-register load, stage STAGE_COUNT-1 = retire.
- RAM_STAGE, 3: stage index whose slot also strobes ram_wren (< STAGE_COUNT).
- REG_STAGE, 4: stage index whose slot also strobes reg_wren (< STAGE_COUNT).
- RESET_HOLD_CYCLES, 2: cycles pipeline_register_reset_n stays low after reset deasserts (≥1).
- COUNTER_WIDTH, 32: width of the performance counters.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  1 = sequencing allowed; 0 = pause in place.
- stall_req  in  STAGE_COUNT  bit k = 1 holds stage k's slot this cycle.
- halt  in  1  request to stop at the next instruction boundary (sticky once sampled).
- resume  in  1  leave HALTED and restart at stage 0.
- stage_wren  out  STAGE_COUNT  one-hot (or zero) per-stage write enable.
- ram_wren  out  1  equals stage_wren[RAM_STAGE].
- reg_wren  out  1  equals stage_wren[REG_STAGE].
- pipeline_register_reset_n  out  1  active-low clear for the pipeline registers.
- active_stage  out  $clog2(STAGE_COUNT)  current stage index.
- halted  out  1  1 in the HALTED state.
- retire  out  1  equals stage_wren[STAGE_COUNT-1].
- cycle_count, instret_count, stall_count  out  COUNTER_WIDTH each  performance counters.

## Operation
- The state machine has three states: RESET, RUN and HALTED.
- Registered state: the FSM state, active_stage, hold counter, halt_pending flag and the three counters.
- reset = 1 in any cycle, including mid-instruction or while HALTED, applies the following at the next edge:
  - state = RESET, active_stage = 0, hold counter = 0, halt_pending = 0.
  - All three counters are cleared to 0.
- RESET state:
  - pipeline_register_reset_n = 0; stage_wren = 0; halted = 0.
  - While reset = 0, the hold counter increments each cycle.
  - When the hold counter = RESET_HOLD_CYCLES-1, the next state is RUN with active_stage = 0.
- RUN state, pipeline_register_reset_n = 1. Outputs are Mealy:
  - stage_wren[k] = (k == active_stage) & run & ~stall_req[k]. All other bits are 0.
- Advance: when stage_wren is nonzero, active_stage moves to active_stage+1, wrapping from STAGE_COUNT-1 to 0.
- No advance when run = 0 or stall_req[active_stage] = 1; stall bits of non-active stages are ignored.
- Halt:
  - halt = 1 in RUN sets halt_pending.
  - When retire = 1 and (halt_pending or halt), the next state is HALTED with active_stage = 0, and halt_pending is cleared.
  - The retiring instruction completes normally.
- HALTED state:
  - stage_wren = 0, halted = 1, pipeline_register_reset_n = 1.
  - halt is ignored.
  - resume = 1 gives next state RUN at stage 0.
- Counters wrap modulo 2^COUNTER_WIDTH:
  - cycle_count increments every RUN cycle with run = 1.
  - stall_count increments every RUN cycle with run = 1 and stall_req[active_stage] = 1.
  - instret_count increments on retire.
  - No counter changes in RESET or HALTED.

## Timing
- Reset values: stage_wren = 0, ram_wren = 0, reg_wren = 0, retire = 0, pipeline_register_reset_n = 0, active_stage = 0, halted = 0, all counters = 0.
- Reset release: cycle 1 is the first cycle with reset = 0.
  - pipeline_register_reset_n = 0 for cycles 1..RESET_HOLD_CYCLES.
  - It goes to 1 in cycle RESET_HOLD_CYCLES+1, the first cycle in which stage_wren[0] can assert.
- An unstalled instruction occupies STAGE_COUNT consecutive cycles; the next instruction's stage 0 follows directly after its retire.
- Each stall cycle adds exactly one cycle of latency; enables are 0 during stall cycles.
- Halt latency: halted = 1 in the cycle after the retire pulse.
- Resume latency: stage_wren[0] can assert in the cycle after resume is sampled.
- At most one stage_wren bit is high in any cycle.

## Test plan
- Reset release with defaults: pipeline_register_reset_n = 0 in cycles 1–2; stage_wren = 00001 in cycle 3, then 00010, 00100, 01000, 10000. ram_wren is high in cycle 6, reg_wren and retire in cycle 7, and instret_count = 1 afterwards.
- stall_req[3] held high for 4 cycles while active_stage = 3: stage_wren = 0 for those 4 cycles, then 01000. Counters after that retire: stall_count = 4, cycle_count = 9, instret_count = 1.
- run = 0 for 3 cycles in the middle of stage 2: no enables, active_stage stays 2, cycle_count and stall_count are frozen. Sequencing continues at stage 2 when run returns to 1.
- halt pulsed for 1 cycle during stage 1: the instruction still retires, halted = 1 in the next cycle, and all enables stay 0 for 10 cycles. After a resume pulse, stage_wren = 00001 in the next cycle.
- Reset asserted during stage 3 with counters nonzero: in the next cycle all outputs are at reset values. Sequencing restarts at stage 0 after RESET_HOLD_CYCLES.
- STAGE_COUNT = 3, COUNTER_WIDTH = 4, no stalls: 16 retires wrap instret_count to 0, and cycle_count wraps every 16 run cycles.
